// File: rtl/gate_truth_checker_if.sv
// -----------------------------------------------------------------------------
// gate_truth_checker_if
// Connection between the truth checker and the two-input basic-gates block.
//   a, b        : gate operands, driven by the checker
//   p q r s t u : AND, OR, XOR, NAND, NOR, XNOR results, driven by the gate block
// Modports:
//   master : checker side (drives a/b, samples p..u)
//   slave  : gate-block side (samples a/b, drives p..u)
// -----------------------------------------------------------------------------
interface gate_truth_checker_if;
   logic a;
   logic b;
   logic p;
   logic q;
   logic r;
   logic s;
   logic t;
   logic u;

   modport master (output a, b, input p, q, r, s, t, u);
   modport slave  (input a, b, output p, q, r, s, t, u);
endinterface

// File: rtl/gate_truth_checker.sv
// -----------------------------------------------------------------------------
// gate_truth_checker
// Drives the basic-gates block through the four operand combinations
// (00, 01, 10, 11) LOOPS times, waits SETTLE cycles after each vector, then
// compares the six gate results against the expected truth table.
//
// Parameters:
//   SETTLE : idle cycles between applying a vector and sampling (0 legal)
//   LOOPS  : number of full 4-vector passes per run (>= 1)
// Ports:
//   clk, rst   : clock (rising edge), synchronous active-high reset
//   start      : run request, honoured only in IDLE or DONE
//   gif        : gate bus (master side: a/b out, p..u in)
//   busy       : run in progress
//   done       : run finished, held until next start or reset
//   pass       : valid with done, high when no vector mismatched
//   err_count  : number of mismatching vectors, saturates at 15
//   fail_vec   : sticky per-gate mismatch flags, bit0 = p ... bit5 = u
// Configuration macro:
//   GATE_CHECK_STOP_ON_FAIL_EN : stop at the first mismatching vector and
//                                freeze a/b on it
// -----------------------------------------------------------------------------
module gate_truth_checker #(
   parameter int SETTLE = 2,
   parameter int LOOPS  = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   gate_truth_checker_if.master gif,
   output logic                 busy,
   output logic                 done,
   output logic                 pass,
   output logic [3:0]           err_count,
   output logic [5:0]           fail_vec
);

   localparam int CW = $clog2(SETTLE + 2);
   localparam int LW = $clog2(LOOPS + 1);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_APPLY  = 3'd1,
      ST_SETTLE = 3'd2,
      ST_CHECK  = 3'd3,
      ST_NEXT   = 3'd4,
      ST_DONE   = 3'd5
   } state_t;

   state_t          state_q, state_d;
   logic [1:0]      idx_q, idx_d;
   logic [LW-1:0]   loop_q, loop_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            a_q, a_d;
   logic            b_q, b_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic            pass_q, pass_d;
   logic [3:0]      err_q, err_d;
   logic [5:0]      fv_q, fv_d;
   logic [5:0]      mis_s;

   // Expected gate results ordered {u,t,s,r,q,p}
   function automatic logic [5:0] expected_outs(input logic a, input logic b);
      return {~(a ^ b), ~(a | b), ~(a & b), a ^ b, a | b, a & b};
   endfunction

   // Saturating increment of the mismatch counter
   function automatic logic [3:0] sat_inc(input logic [3:0] v);
      return (v == 4'd15) ? v : v + 4'd1;
   endfunction

   // Next-state and next-output computation for the sequencer
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      loop_d  = loop_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      b_d     = b_q;
      busy_d  = busy_q;
      done_d  = done_q;
      pass_d  = pass_q;
      err_d   = err_q;
      fv_d    = fv_q;
      mis_s   = 6'd0;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               err_d   = 4'd0;
               fv_d    = 6'd0;
               idx_d   = 2'd0;
               loop_d  = '0;
               done_d  = 1'b0;
               pass_d  = 1'b0;
               busy_d  = 1'b1;
               state_d = ST_APPLY;
            end else begin
               state_d = state_q;
            end
         end
         ST_APPLY: begin
            a_d   = idx_q[1];
            b_d   = idx_q[0];
            cnt_d = '0;
            if (SETTLE > 0) begin
               state_d = ST_SETTLE;
            end else begin
               state_d = ST_CHECK;
            end
         end
         ST_SETTLE: begin
            if (int'(cnt_q) >= SETTLE - 1) begin
               state_d = ST_CHECK;
            end else begin
               cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
            end
         end
         ST_CHECK: begin
            // a_q/b_q are the operands currently presented to the gate block
            mis_s = expected_outs(a_q, b_q) ^
                    {gif.u, gif.t, gif.s, gif.r, gif.q, gif.p};
            fv_d  = fv_q | mis_s;
            if (mis_s != 6'd0) begin
               err_d = sat_inc(err_q);
`ifdef GATE_CHECK_STOP_ON_FAIL_EN
               state_d = ST_DONE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               pass_d  = 1'b0;
`else
               state_d = ST_NEXT;
`endif
            end else begin
               state_d = ST_NEXT;
            end
         end
         ST_NEXT: begin
            if ((idx_q == 2'd3) && (int'(loop_q) == LOOPS - 1)) begin
               state_d = ST_DONE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               pass_d  = (err_q == 4'd0);
            end else begin
               idx_d = idx_q + 2'd1;
               if (idx_q == 2'd3) begin
                  loop_d = loop_q + {{(LW-1){1'b0}}, 1'b1};
               end else begin
                  loop_d = loop_q;
               end
               state_d = ST_APPLY;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         idx_q   <= 2'd0;
         loop_q  <= '0;
         cnt_q   <= '0;
         a_q     <= 1'b0;
         b_q     <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
         err_q   <= 4'd0;
         fv_q    <= 6'd0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         loop_q  <= loop_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         pass_q  <= pass_d;
         err_q   <= err_d;
         fv_q    <= fv_d;
      end
   end

   assign gif.a     = a_q;
   assign gif.b     = b_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign pass      = pass_q;
   assign err_count = err_q;
   assign fail_vec  = fv_q;

endmodule

// File: tb/tb_gate_truth_checker.sv
// -----------------------------------------------------------------------------
// tb_gate_truth_checker
// Three checker instances (SETTLE/LOOPS = 2/1, 2/2, 0/1) each looking at a
// behavioural gate model whose outputs can be corrupted per operand vector by
// an XOR fault mask. The expected verdict of each run is derived from the
// masks alone: which vectors are corrupted, how often they are visited and
// when the run has to end.
// -----------------------------------------------------------------------------
module tb_gate_truth_checker;

   logic clk;
   logic rst;
   logic start;

   int checks;
   int errors;

   localparam int SP0 = 2, LP0 = 1;
   localparam int SP1 = 2, LP1 = 2;
   localparam int SP2 = 0, LP2 = 1;
   int s_par [3] = '{SP0, SP1, SP2};
   int l_par [3] = '{LP0, LP1, LP2};

   logic [5:0] mask [3][4];

   logic       busy_o [3];
   logic       done_o [3];
   logic       pass_o [3];
   logic [3:0] err_o  [3];
   logic [5:0] fv_o   [3];

   gate_truth_checker_if gif0 ();
   gate_truth_checker_if gif1 ();
   gate_truth_checker_if gif2 ();

   // Truth table from counting the ones among the operands, {u,t,s,r,q,p}
   function automatic logic [5:0] gate_ref(input logic a, input logic b);
      int ones;
      logic [5:0] res;
      ones   = int'(a) + int'(b);
      res[0] = (ones == 2);
      res[1] = (ones >= 1);
      res[2] = (ones == 1);
      res[3] = (ones != 2);
      res[4] = (ones == 0);
      res[5] = (ones != 1);
      return res;
   endfunction

   assign {gif0.u, gif0.t, gif0.s, gif0.r, gif0.q, gif0.p} =
          gate_ref(gif0.a, gif0.b) ^ mask[0][{gif0.a, gif0.b}];
   assign {gif1.u, gif1.t, gif1.s, gif1.r, gif1.q, gif1.p} =
          gate_ref(gif1.a, gif1.b) ^ mask[1][{gif1.a, gif1.b}];
   assign {gif2.u, gif2.t, gif2.s, gif2.r, gif2.q, gif2.p} =
          gate_ref(gif2.a, gif2.b) ^ mask[2][{gif2.a, gif2.b}];

   gate_truth_checker #(.SETTLE(SP0), .LOOPS(LP0)) dut0 (
      .clk(clk), .rst(rst), .start(start), .gif(gif0),
      .busy(busy_o[0]), .done(done_o[0]), .pass(pass_o[0]),
      .err_count(err_o[0]), .fail_vec(fv_o[0]));
   gate_truth_checker #(.SETTLE(SP1), .LOOPS(LP1)) dut1 (
      .clk(clk), .rst(rst), .start(start), .gif(gif1),
      .busy(busy_o[1]), .done(done_o[1]), .pass(pass_o[1]),
      .err_count(err_o[1]), .fail_vec(fv_o[1]));
   gate_truth_checker #(.SETTLE(SP2), .LOOPS(LP2)) dut2 (
      .clk(clk), .rst(rst), .start(start), .gif(gif2),
      .busy(busy_o[2]), .done(done_o[2]), .pass(pass_o[2]),
      .err_count(err_o[2]), .fail_vec(fv_o[2]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic dut_a(input int i);
      case (i)
         0:       return gif0.a;
         1:       return gif1.a;
         default: return gif2.a;
      endcase
   endfunction

   function automatic logic dut_b(input int i);
      case (i)
         0:       return gif0.b;
         1:       return gif1.b;
         default: return gif2.b;
      endcase
   endfunction

   task automatic check_all_zero(input string tag);
      for (int i = 0; i < 3; i++) begin
         check($sformatf("%s_d%0d_busy", tag, i), 32'(busy_o[i]), 32'd0);
         check($sformatf("%s_d%0d_done", tag, i), 32'(done_o[i]), 32'd0);
         check($sformatf("%s_d%0d_pass", tag, i), 32'(pass_o[i]), 32'd0);
         check($sformatf("%s_d%0d_err",  tag, i), 32'(err_o[i]),  32'd0);
         check($sformatf("%s_d%0d_fv",   tag, i), 32'(fv_o[i]),   32'd0);
         check($sformatf("%s_d%0d_ab",   tag, i), 32'({dut_a(i), dut_b(i)}), 32'd0);
      end
   endtask

   // One complete run: derive the verdict from the masks, pulse start, then
   // walk edge by edge checking done timing and the final verdict.
   task automatic run(input string tag, input int repulse_at, input bit seq_check);
      int exp_err [3];
      int exp_fv  [3];
      int exp_n   [3];
      int exp_ab  [3];
      int max_n;
      bit stopped;
      int k;
      max_n = 0;
      for (int i = 0; i < 3; i++) begin
         exp_err[i] = 0;
         exp_fv[i]  = 0;
         exp_ab[i]  = 3;
         exp_n[i]   = 4 * l_par[i] * (s_par[i] + 3);
         stopped    = 1'b0;
         k          = 0;
         for (int l = 0; l < l_par[i]; l++) begin
            for (int v = 0; v < 4; v++) begin
               if (!stopped) begin
                  k++;
                  if (mask[i][v] != 6'd0) begin
                     exp_err[i] = (exp_err[i] < 15) ? exp_err[i] + 1 : 15;
                     exp_fv[i]  = exp_fv[i] | int'(mask[i][v]);
`ifdef GATE_CHECK_STOP_ON_FAIL_EN
                     stopped   = 1'b1;
                     exp_ab[i] = v;
                     exp_n[i]  = k * (s_par[i] + 3) - 1;
`endif
                  end
               end
            end
         end
         if (exp_n[i] > max_n) max_n = exp_n[i];
      end

      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check($sformatf("%s_d%0d_start_busy", tag, i), 32'(busy_o[i]), 32'd1);
         check($sformatf("%s_d%0d_start_done", tag, i), 32'(done_o[i]), 32'd0);
         check($sformatf("%s_d%0d_start_err",  tag, i), 32'(err_o[i]),  32'd0);
         check($sformatf("%s_d%0d_start_fv",   tag, i), 32'(fv_o[i]),   32'd0);
      end

      for (int e = 1; e <= max_n + 1; e++) begin
         if (e == repulse_at) start = 1'b1;
         tick();
         start = 1'b0;
         if (seq_check) begin
            for (int v = 0; v < 4; v++) begin
               if (e == 1 + v * (SP0 + 3)) begin
                  check($sformatf("%s_seq%0d", tag, v), 32'({gif0.a, gif0.b}), 32'(v));
               end
            end
         end
         for (int i = 0; i < 3; i++) begin
            if (e == exp_n[i] - 1) begin
               check($sformatf("%s_d%0d_early_done", tag, i), 32'(done_o[i]), 32'd0);
            end
            if (e == exp_n[i]) begin
               check($sformatf("%s_d%0d_done", tag, i), 32'(done_o[i]), 32'd1);
               check($sformatf("%s_d%0d_busy", tag, i), 32'(busy_o[i]), 32'd0);
               check($sformatf("%s_d%0d_pass", tag, i), 32'(pass_o[i]), 32'(exp_err[i] == 0));
               check($sformatf("%s_d%0d_err",  tag, i), 32'(err_o[i]),  32'(exp_err[i]));
               check($sformatf("%s_d%0d_fv",   tag, i), 32'(fv_o[i]),   32'(exp_fv[i]));
               check($sformatf("%s_d%0d_ab",   tag, i), 32'({dut_a(i), dut_b(i)}), 32'(exp_ab[i]));
            end
         end
      end
   endtask

   task automatic set_masks_clean();
      for (int i = 0; i < 3; i++)
         for (int v = 0; v < 4; v++)
            mask[i][v] = 6'd0;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst    = 1'b1;
      start  = 1'b0;
      set_masks_clean();
      tick();
      tick();
      check_all_zero("reset");
      rst = 1'b0;
      tick();
      check_all_zero("idle");

      // Correct gates: clean run and operand ordering
      run("clean", -1, 1'b1);

      // XOR stuck at 0 on every instance: corrupts vectors 01 and 10
      for (int i = 0; i < 3; i++) begin
         mask[i][1] = 6'b000100;
         mask[i][2] = 6'b000100;
      end
      run("xor_sa0", -1, 1'b0);

      // Start re-pulsed mid-run is ignored
      set_masks_clean();
      run("repulse", 7, 1'b1);

      // Randomized fault patterns
      for (int n = 0; n < 6; n++) begin
         for (int i = 0; i < 3; i++)
            for (int v = 0; v < 4; v++)
               mask[i][v] = ($urandom_range(0, 2) == 0) ? 6'($urandom) : 6'd0;
         run($sformatf("rand%0d", n), -1, 1'b0);
      end

      // Reset in the middle of a run
      for (int i = 0; i < 3; i++) mask[i][3] = 6'b100000;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int e = 1; e < 12; e++) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_all_zero("midrst");

      set_masks_clean();
      run("after_rst", -1, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Hard time limit so the bench always ends
   initial begin
      #2000000;
      $display("FAIL timeout: observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
